// File: rtl/vec_mem_seq.sv
// Vector memory sequencer: serialises a LANES x LANE_W vector load/store into one
// 32-bit data-memory access per lane. Define VEC_MASK_EN to add per-lane masking.
module vec_mem_seq #(
    parameter int LANES  = 10,
    parameter int LANE_W = 16,
    parameter int ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      VecMemM,
    input  logic                      VecWriteM,
    input  logic                      AbortM,
    input  logic [ADDR_W-1:0]         BaseAddrM,
    input  logic [LANES*LANE_W-1:0]   WriteDataVM,
`ifdef VEC_MASK_EN
    input  logic [LANES-1:0]          LaneMaskM,
`endif
    input  logic [31:0]               MemRD,
    output logic [ADDR_W-1:0]         MemAddr,
    output logic                      MemWE,
    output logic [31:0]               MemWD,
    output logic [LANES*LANE_W-1:0]   ReadDataVM,
    output logic                      StallVec,
    output logic                      VecDone
);
    localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VEC_W     = LANES * LANE_W;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t               state;
    logic [LANE_BITS-1:0] lane;
    logic [ADDR_W-1:0]    base_q;
    logic [VEC_W-1:0]     wdata_q;
    logic                 write_q;
    logic [LANES-1:0]     mask_q;
    logic [LANES-1:0]     start_mask;
    logic                 start;
    logic [LANE_BITS:0]   first_lane;
    logic [LANE_BITS:0]   next_lane;
    logic [LANE_W-1:0]    lane_wdata;
    logic                 unused_rd;

`ifdef VEC_MASK_EN
    assign start_mask = LaneMaskM;
`else
    assign start_mask = '1;
`endif

    // Lowest set mask bit at or above 'from'; the MSB of the result flags a hit.
    function automatic logic [LANE_BITS:0] find_lane(input logic [LANES-1:0] m, input int from);
        logic [LANE_BITS:0] r;
        r = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (m[i] && i >= from) r = {1'b1, LANE_BITS'(i)};
        end
        return r;
    endfunction

    assign start      = VecMemM & ~AbortM;
    assign first_lane = find_lane(start_mask, 0);
    assign next_lane  = find_lane(mask_q, int'(lane) + 1);
    assign lane_wdata = wdata_q[lane*LANE_W +: LANE_W];
    assign unused_rd  = ^MemRD[31:LANE_W];

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        MemAddr  = '0;
        MemWE    = 1'b0;
        MemWD    = '0;
        StallVec = 1'b0;
        VecDone  = 1'b0;
        case (state)
            // The stall must rise in the start cycle itself, and stay low under reset.
            IDLE:   StallVec = start & reset;
            ACCESS: begin
                MemAddr  = base_q + ADDR_W'({lane, 2'b00});
                MemWE    = write_q & ~AbortM;
                MemWD    = write_q ? 32'(lane_wdata) : '0;
                StallVec = 1'b1;
            end
            DONE:    VecDone = 1'b1;
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lane       <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            mask_q     <= '0;
            ReadDataVM <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q  <= BaseAddrM;
                        wdata_q <= WriteDataVM;
                        write_q <= VecWriteM;
                        mask_q  <= start_mask;
                        lane    <= first_lane[LANE_BITS-1:0];
                        state   <= first_lane[LANE_BITS] ? ACCESS : DONE;
                    end
                end
                ACCESS: begin
                    if (AbortM) begin
                        state <= IDLE;
                        lane  <= '0;
                    end else begin
                        if (!write_q) ReadDataVM[lane*LANE_W +: LANE_W] <= MemRD[LANE_W-1:0];
                        if (next_lane[LANE_BITS]) begin
                            lane <= next_lane[LANE_BITS-1:0];
                        end else begin
                            state <= DONE;
                            lane  <= '0;
                        end
                    end
                end
                // VecMemM still shows the finished instruction here, so it is ignored.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq: a table of load/store vectors plus abort,
// back-to-back and mid-access reset sequences against a small word memory.
module tb_vec_mem_seq;
    logic         clk;
    logic         reset;
    logic         VecMemM;
    logic         VecWriteM;
    logic         AbortM;
    logic [31:0]  BaseAddrM;
    logic [159:0] WriteDataVM;
    logic [9:0]   lane_mask;
    logic [31:0]  MemRD;
    logic [31:0]  MemAddr;
    logic         MemWE;
    logic [31:0]  MemWD;
    logic [159:0] ReadDataVM;
    logic         StallVec;
    logic         VecDone;

    logic [31:0]  mem [256];
    logic [31:0]  wr_addr [$];
    logic [31:0]  wr_data [$];
    int           stall_n;
    int           total;
    int           bad;

    typedef struct {
        string        name;
        logic         wr;
        logic [31:0]  base;
        logic [159:0] wd;
        logic [9:0]   mask;
        logic [159:0] exp_rd;
        int           exp_done;
        int           exp_nwr;
    } vec_t;

    vec_t tbl [$];

    vec_mem_seq dut (
        .clk        (clk),
        .reset      (reset),
        .VecMemM    (VecMemM),
        .VecWriteM  (VecWriteM),
        .AbortM     (AbortM),
        .BaseAddrM  (BaseAddrM),
        .WriteDataVM(WriteDataVM),
`ifdef VEC_MASK_EN
        .LaneMaskM  (lane_mask),
`endif
        .MemRD      (MemRD),
        .MemAddr    (MemAddr),
        .MemWE      (MemWE),
        .MemWD      (MemWD),
        .ReadDataVM (ReadDataVM),
        .StallVec   (StallVec),
        .VecDone    (VecDone)
    );

    assign MemRD = mem[MemAddr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [159:0] pack(input logic [15:0] first, input logic [15:0] step);
        logic [159:0] r;
        for (int i = 0; i < 10; i++) r[i*16 +: 16] = first + step * 16'(i);
        return r;
    endfunction

    // One observation per cycle at the falling edge; stores also update the memory model.
    task automatic sample_cycle();
        @(negedge clk);
        if (StallVec) stall_n++;
        if (MemWE) begin
            wr_addr.push_back(MemAddr);
            wr_data.push_back(MemWD);
            mem[MemAddr[9:2]] = MemWD;
        end
    endtask

    task automatic clear_log();
        stall_n = 0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    // Starts an operation in the current cycle; returns one cycle after VecDone.
    // Operands are scrambled after the start cycle to prove they were latched.
    task automatic run_op(input vec_t v, input bit keep_req, output int done_at);
        VecMemM     = 1'b1;
        VecWriteM   = v.wr;
        BaseAddrM   = v.base;
        WriteDataVM = v.wd;
        lane_mask   = v.mask;
        AbortM      = 1'b0;
        clear_log();
        done_at = -1;
        for (int k = 0; k < 40 && done_at < 0; k++) begin
            sample_cycle();
            if (VecDone) done_at = k;
            @(posedge clk);
            #1;
            if (k == 0) begin
                BaseAddrM   = 32'hFFFF_FFFF;
                WriteDataVM = ~v.wd;
                VecWriteM   = ~v.wr;
                lane_mask   = ~v.mask;
            end
        end
        if (!keep_req) VecMemM = 1'b0;
    endtask

    task automatic check_op(input vec_t v, input int done_at);
        int ln;
        check({v.name, "_done_at"}, done_at, v.exp_done);
        check({v.name, "_stall_cycles"}, stall_n, v.exp_done);
        check({v.name, "_nwrites"}, wr_addr.size(), v.exp_nwr);
        ln = 0;
        foreach (wr_addr[j]) begin
            while (ln < 10 && !v.mask[ln]) ln++;
            check({v.name, "_wr_addr"}, wr_addr[j], v.base + 32'(ln * 4));
            check({v.name, "_wr_data"}, wr_data[j], {16'h0, v.wd[ln*16 +: 16]});
            ln++;
        end
        check({v.name, "_rd"}, ReadDataVM, v.exp_rd);
    endtask

    initial begin
        logic [159:0] wrap_rd;
        logic [159:0] mask_rd;
        logic [159:0] b2b_rd;
        int           done_at;

        total = 0;
        bad   = 0;

        for (int k = 0; k < 256; k++) mem[k] = {16'hDEAD, 16'h5000 + 16'(k)};
        for (int i = 0; i < 10; i++) mem[8'h40 + i] = 32'hDEAD_A000 + 32'(i);

        for (int i = 0; i < 4; i++) wrap_rd[i*16 +: 16] = 16'h50FC + 16'(i);
        for (int i = 4; i < 10; i++) wrap_rd[i*16 +: 16] = 16'h5000 + 16'(i - 4);
        mask_rd = wrap_rd;
        mask_rd[16 +: 16] = 16'hA001;
        mask_rd[64 +: 16] = 16'hA004;

        tbl.push_back('{"ld_100", 1'b0, 32'h100, '0, 10'h3FF, pack(16'hA000, 16'h1), 11, 0});
        tbl.push_back('{"st_200", 1'b1, 32'h200, pack(16'h0, 16'h1111), 10'h3FF,
                        pack(16'hA000, 16'h1), 11, 10});
        tbl.push_back('{"ld_200", 1'b0, 32'h200, '0, 10'h3FF, pack(16'h0, 16'h1111), 11, 0});
        tbl.push_back('{"ld_wrap", 1'b0, 32'hFFFF_FFF0, '0, 10'h3FF, wrap_rd, 11, 0});
`ifdef VEC_MASK_EN
        tbl.push_back('{"st_mask", 1'b1, 32'h300, pack(16'hB000, 16'h1), 10'b10_0000_0101,
                        wrap_rd, 4, 3});
        tbl.push_back('{"ld_mask", 1'b0, 32'h100, '0, 10'b00_0001_0010, mask_rd, 3, 0});
        tbl.push_back('{"st_mask0", 1'b1, 32'h300, pack(16'hC000, 16'h1), 10'h000,
                        mask_rd, 1, 0});
`endif

        reset       = 1'b0;
        VecMemM     = 1'b0;
        VecWriteM   = 1'b0;
        AbortM      = 1'b0;
        BaseAddrM   = '0;
        WriteDataVM = '0;
        lane_mask   = '1;
        stall_n     = 0;
        @(negedge clk);
        check("rst_memaddr", MemAddr, 32'h0);
        check("rst_memwe", MemWE, 1'b0);
        check("rst_memwd", MemWD, 32'h0);
        check("rst_rd", ReadDataVM, 160'h0);
        check("rst_stall", StallVec, 1'b0);
        check("rst_done", VecDone, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[n]) begin
            run_op(tbl[n], 1'b0, done_at);
            check_op(tbl[n], done_at);
            @(posedge clk);
            #1;
        end

        // Abort raised in the fourth ACCESS cycle (lane 3) of a store.
        clear_log();
        VecMemM     = 1'b1;
        VecWriteM   = 1'b1;
        BaseAddrM   = 32'h200;
        WriteDataVM = pack(16'h7000, 16'h1);
        lane_mask   = '1;
        begin
            int done_seen;
            done_seen = 0;
            for (int k = 0; k < 8; k++) begin
                sample_cycle();
                if (VecDone) done_seen++;
                if (k == 4) check("abort_we_low", MemWE, 1'b0);
                if (k == 5) check("abort_stall_after", StallVec, 1'b0);
                @(posedge clk);
                #1;
                AbortM = (k == 3);
                if (k == 4) VecMemM = 1'b0;
            end
            check("abort_no_done", done_seen, 0);
        end
        check("abort_nwrites", wr_addr.size(), 3);
        check("abort_stall_cycles", stall_n, 5);
        for (int j = 0; j < 3 && j < wr_addr.size(); j++) begin
            check("abort_wr_addr", wr_addr[j], 32'h200 + 32'(4 * j));
            check("abort_wr_data", wr_data[j], 32'h7000 + 32'(j));
        end
        check("abort_lane3_kept", mem[8'h83], 32'h3333);

        // Two loads back to back: the second request is held through DONE.
        b2b_rd = pack(16'h0, 16'h1111);
        for (int i = 0; i < 3; i++) b2b_rd[i*16 +: 16] = 16'h7000 + 16'(i);
        run_op('{"b2b_a", 1'b0, 32'h100, '0, 10'h3FF, pack(16'hA000, 16'h1), 11, 0},
               1'b1, done_at);
        check("b2b_a_done_at", done_at, 11);
        check("b2b_a_rd", ReadDataVM, pack(16'hA000, 16'h1));
        run_op('{"b2b_b", 1'b0, 32'h200, '0, 10'h3FF, b2b_rd, 11, 0}, 1'b0, done_at);
        check("b2b_b_done_at", done_at, 11);
        check("b2b_b_stall_cycles", stall_n, 11);
        check("b2b_b_rd", ReadDataVM, b2b_rd);
        @(posedge clk);
        #1;

        // Reset asserted while lane 5 of a load is in flight.
        VecMemM   = 1'b1;
        VecWriteM = 1'b0;
        BaseAddrM = 32'h100;
        lane_mask = '1;
        repeat (6) @(posedge clk);
        #1;
        check("rstmid_pre_lane4", ReadDataVM[64 +: 16], 16'hA004);
        check("rstmid_pre_addr", MemAddr, 32'h114);
        reset = 1'b0;
        #1;
        check("rstmid_rd", ReadDataVM, 160'h0);
        check("rstmid_stall", StallVec, 1'b0);
        check("rstmid_memaddr", MemAddr, 32'h0);
        check("rstmid_memwe", MemWE, 1'b0);
        check("rstmid_memwd", MemWD, 32'h0);
        check("rstmid_done", VecDone, 1'b0);
        VecMemM = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        run_op('{"post_rst", 1'b0, 32'h100, '0, 10'h3FF, pack(16'hA000, 16'h1), 11, 0},
               1'b0, done_at);
        check_op('{"post_rst", 1'b0, 32'h100, '0, 10'h3FF, pack(16'hA000, 16'h1), 11, 0},
                 done_at);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vec_mem_seq.md
# vec_mem_seq

Vector memory sequencer for the pipelined ARM core with the 10-lane × 16-bit vector extension. When a vector load or store reaches the Memory stage, it stalls the pipeline and serialises the access into one 32-bit data-memory transaction per lane. For loads, it gathers the lanes into a packed vector register for Writeback; for stores, it scatters the packed write vector to memory. It sits between the Memory-stage pipeline registers, the data memory port and the hazard unit.

## Interface
Parameters:
- LANES, 10, number of vector lanes
- LANE_W, 16, bits per lane
- ADDR_W, 32, memory address width

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- VecMemM  in  1  a vector load/store instruction is valid in the Memory stage
- VecWriteM  in  1  1 = store, 0 = load; sampled at start
- AbortM  in  1  flush of the Memory-stage instruction
- BaseAddrM  in  ADDR_W  vector base address (ALUOutM); sampled at start
- WriteDataVM  in  LANES*LANE_W  packed store data, lane i at bits [i*LANE_W +: LANE_W]; sampled at start
- MemRD  in  32  data-memory read data; combinational w.r.t. MemAddr
- MemAddr  out  ADDR_W  data-memory address
- MemWE  out  1  data-memory write enable
- MemWD  out  32  data-memory write data
- ReadDataVM  out  LANES*LANE_W  gathered load vector, same packing as WriteDataVM
- StallVec  out  1  stall request to the hazard unit; freezes F/D/E/M
- VecDone  out  1  one-cycle pulse when the access completes

## Operation
- FSM states: IDLE, ACCESS, DONE. A lane counter `lane` runs from 0 to LANES-1.
- IDLE:
  - If VecMemM=1 and AbortM=0: latch base, write data and direction; set lane=0; go to ACCESS.
  - StallVec = VecMemM & ~AbortM (combinational, so the pipeline freezes in the start cycle).
- ACCESS:
  - MemAddr = base + (lane << 2).
  - Load: at the clock edge, ReadDataVM lane[lane] <= MemRD[LANE_W-1:0].
  - Store: MemWE=1 and MemWD = {zero-extend, data lane[lane]}.
  - lane increments each cycle. After the last lane, go to DONE.
  - StallVec=1.
- DONE:
  - VecDone=1 and StallVec=0.
  - VecMemM is ignored in this cycle, because it still reflects the same instruction. Go to IDLE.
- Outside ACCESS: MemWE=0, MemAddr=0, MemWD=0.
- ReadDataVM holds its value until the next load overwrites lanes. Stores never modify it.
- AbortM=1 in ACCESS: return to IDLE next edge with no VecDone. Lanes already written or loaded stay as they are.
- AbortM=1 together with a start request in IDLE: abort wins and no access begins.
- Address arithmetic wraps modulo 2^ADDR_W.

## Timing
- Reset (reset=0) values: state=IDLE, lane=0, latches=0, ReadDataVM=0, MemWE=0, MemAddr=0, MemWD=0, StallVec=0, VecDone=0.
- Reset asserted mid-access forces all of the above immediately. The partial store is not completed.
- Full access from start cycle T:
  - ACCESS runs T+1 … T+LANES.
  - DONE at T+LANES+1.
  - StallVec is high for T … T+LANES, i.e. LANES+1 cycles.
- Back-to-back vector operations: the next instruction is seen in the IDLE cycle at T+LANES+2. There is one non-stalled gap cycle (DONE) between operations.

## Configuration
- VEC_MASK_EN defined:
  - Adds input LaneMaskM [LANES-1:0], sampled at start.
  - ACCESS visits only lanes whose mask bit is 1, in ascending order. The counter jumps to the next set bit.
  - Masked load lanes keep their previous ReadDataVM value. Masked store lanes generate no write.
  - An all-zero mask goes directly from IDLE to DONE.
  - ACCESS lasts popcount(mask) cycles.
- VEC_MASK_EN undefined: no LaneMaskM port; every lane is accessed.

## Test plan
- Load from base 0x100, memory word at 0x100+4i = 0xA000+i → ReadDataVM lane i = 0xA000+i; VecDone at T+11; StallVec high for 11 cycles.
- Store with lane i = 0x1111*i (low 16 bits) at base 0x200 → MemWE high for 10 cycles, addresses 0x200…0x224, MemWD = 0x0000_1111*i.
- AbortM pulsed at the fourth ACCESS cycle of a store → only 0x200…0x208 are written, no VecDone, StallVec low next cycle.
- Two vector loads back to back → second start at T+12, no lost or duplicated access.
- reset=0 at lane 5 of a load → all outputs zero immediately; after release, IDLE and a new load completes normally.
- VEC_MASK_EN, mask=10'b10_0000_0101 store → writes only lanes 0, 2 and 9; VecDone at T+4. Mask=0 → VecDone at T+1.
